// File: rtl/filt_color_matrix_if.sv
// Shared video types: the RGB pixel word and the per-pixel sideband bundle.

package vid_pkg;
    localparam int RGBW = 8;

    typedef struct packed {
        logic [RGBW-1:0] r;
        logic [RGBW-1:0] g;
        logic [RGBW-1:0] b;
    } pixel_t;
endpackage

interface vid_sideband_if #(
    parameter int XW = 10,
    parameter int YW = 10
);
    logic          de;
    logic          sof;
    logic          eol;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    modport source (output de, sof, eol, x, y);
    modport sink   (input  de, sof, eol, x, y);
endinterface

// File: rtl/filt_color_matrix.sv
// Per-pixel 3x3 colour matrix with offsets and saturation, built-in BT.601 /
// BT.709 greyscale rows and bit-exact bypass. Mode and coefficients are held
// in a shadow bank and committed atomically on sof; latency is 4 cycles.

module filt_color_matrix
    import vid_pkg::*;
#(
    parameter int XW   = 10,
    parameter int YW   = 10,
    parameter int CW   = 18,
    parameter int FRAC = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    ctrl,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
    output logic          cfg_pend,
    input  pixel_t        px_in,
    output pixel_t        px_out,
    vid_sideband_if.sink   sb_in,
    vid_sideband_if.source sb_out
);
    localparam int IW = RGBW + 1;   // zero-extended input channel, signed
    localparam int PW = CW + IW;    // product width
    localparam int SW = PW + 2;     // row sum with two bits of headroom
    localparam int OW = SW + 1;     // shifted sum plus offset

    localparam logic [1:0] MODE_BYP = 2'b00;
    localparam logic [1:0] MODE_601 = 2'b01;
    localparam logic [1:0] MODE_709 = 2'b10;

    localparam logic signed [CW-1:0] COEF_ONE   = CW'(1 << FRAC);
    localparam logic signed [SW-1:0] ROUND_HALF = SW'(1 << (FRAC - 1));

    // Built-in greyscale row; the same row feeds all three outputs.
    function automatic logic signed [CW-1:0] grey_coef(input logic [1:0] mode, input int col);
        logic signed [CW-1:0] c;
        case (col)
            0:       c = (mode == MODE_601) ? CW'(4899) : CW'(3483);
            1:       c = (mode == MODE_601) ? CW'(9617) : CW'(11718);
            default: c = (mode == MODE_601) ? CW'(1868) : CW'(1183);
        endcase
        return c;
    endfunction

    function automatic logic signed [IW-1:0] in_ext(input pixel_t px, input int ch);
        logic [RGBW-1:0] v;
        case (ch)
            0:       v = px.r;
            1:       v = px.g;
            default: v = px.b;
        endcase
        return $signed({1'b0, v});
    endfunction

    function automatic logic signed [PW-1:0] mul(input logic signed [CW-1:0] c,
                                                 input logic signed [IW-1:0] p);
        logic signed [PW-1:0] ce;
        logic signed [PW-1:0] pe;
        ce = {{(PW-CW){c[CW-1]}}, c};
        pe = {{(PW-IW){p[IW-1]}}, p};
        return ce * pe;
    endfunction

    function automatic logic signed [SW-1:0] row_sum(input logic signed [PW-1:0] a,
                                                     input logic signed [PW-1:0] b,
                                                     input logic signed [PW-1:0] c);
        logic signed [SW-1:0] s;
        s = {{2{a[PW-1]}}, a} + {{2{b[PW-1]}}, b} + {{2{c[PW-1]}}, c} + ROUND_HALF;
        return s;
    endfunction

    // Arithmetic shift of the pre-rounded sum, add offset, clamp to pixel range.
    function automatic logic [RGBW-1:0] sat_pix(input logic signed [SW-1:0] sum,
                                                input logic signed [IW-1:0] off);
        logic signed [SW-1:0] shifted;
        logic        [OW-1:0] v;
        logic        [OW-1:0] pix_max;
        shifted = sum >>> FRAC;
        v       = {shifted[SW-1], shifted} + {{(OW-IW){off[IW-1]}}, off};
        pix_max = {{(OW-RGBW){1'b0}}, {RGBW{1'b1}}};
        if (v[OW-1])          return '0;
        else if (v > pix_max) return '1;
        else                  return v[RGBW-1:0];
    endfunction

    logic signed [CW-1:0] sh_coef  [9];
    logic signed [IW-1:0] sh_off   [3];
    logic signed [CW-1:0] act_coef [9];
    logic signed [IW-1:0] act_off  [3];
    logic [1:0]           act_mode;

    logic [1:0]           eff_mode;
    logic signed [CW-1:0] eff_coef [9];
    logic signed [IW-1:0] eff_off  [3];

    logic                 wr_ok;

    logic [1:0]           mode_p0, mode_p1, mode_p2;
    pixel_t               px_p0, px_p1, px_p2;
    logic signed [CW-1:0] coef_p0 [9];
    logic signed [IW-1:0] off_p0 [3], off_p1 [3], off_p2 [3];
    logic signed [PW-1:0] prod_p1 [9];
    logic signed [SW-1:0] sum_p2 [3];
    logic                 de_p0, de_p1, de_p2;
    logic                 sof_p0, sof_p1, sof_p2;
    logic                 eol_p0, eol_p1, eol_p2;
    logic [XW-1:0]        x_p0, x_p1, x_p2;
    logic [YW-1:0]        y_p0, y_p1, y_p2;

    assign wr_ok = cfg_we && (cfg_addr <= 4'd11);

    // Shadow bank writes and the pending-commit flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) sh_coef[i] <= (i % 4 == 0) ? COEF_ONE : '0;
            for (int i = 0; i < 3; i++) sh_off[i]  <= '0;
            cfg_pend <= 1'b0;
        end else begin
            if (wr_ok) begin
                if (cfg_addr <= 4'd8)       sh_coef[cfg_addr] <= cfg_wdata;
                else if (cfg_addr == 4'd9)  sh_off[0] <= cfg_wdata[IW-1:0];
                else if (cfg_addr == 4'd10) sh_off[1] <= cfg_wdata[IW-1:0];
                else                        sh_off[2] <= cfg_wdata[IW-1:0];
                cfg_pend <= 1'b1;
            end else if (sb_in.sof) begin
                cfg_pend <= 1'b0;
            end
        end
    end

    // Active set commits from ctrl and the pre-write shadow bank on sof.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) act_coef[i] <= (i % 4 == 0) ? COEF_ONE : '0;
            for (int i = 0; i < 3; i++) act_off[i]  <= '0;
            act_mode <= MODE_BYP;
        end else if (sb_in.sof) begin
            act_coef <= sh_coef;
            act_off  <= sh_off;
            act_mode <= ctrl;
        end
    end

    // Values seen by the current pixel: the sof pixel already uses the commit.
    always_comb begin
        eff_mode = sb_in.sof ? ctrl : act_mode;
        for (int i = 0; i < 9; i++) eff_coef[i] = sb_in.sof ? sh_coef[i] : act_coef[i];
        for (int i = 0; i < 3; i++) eff_off[i]  = sb_in.sof ? sh_off[i]  : act_off[i];
        if (eff_mode == MODE_601 || eff_mode == MODE_709) begin
            for (int i = 0; i < 9; i++) eff_coef[i] = grey_coef(eff_mode, i % 3);
            for (int i = 0; i < 3; i++) eff_off[i]  = '0;
        end
    end

    // S0: capture pixel, sideband and the effective mode/values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_p0 <= MODE_BYP;
            px_p0   <= '0;
            for (int i = 0; i < 9; i++) coef_p0[i] <= '0;
            for (int i = 0; i < 3; i++) off_p0[i]  <= '0;
            de_p0 <= 1'b0; sof_p0 <= 1'b0; eol_p0 <= 1'b0;
            x_p0  <= '0;   y_p0   <= '0;
        end else begin
            mode_p0 <= eff_mode;
            px_p0   <= px_in;
            coef_p0 <= eff_coef;
            off_p0  <= eff_off;
            de_p0 <= sb_in.de; sof_p0 <= sb_in.sof; eol_p0 <= sb_in.eol;
            x_p0  <= sb_in.x;  y_p0   <= sb_in.y;
        end
    end

    // S1: nine products, output row r uses coefficients 3r..3r+2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_p1 <= MODE_BYP;
            px_p1   <= '0;
            for (int i = 0; i < 9; i++) prod_p1[i] <= '0;
            for (int i = 0; i < 3; i++) off_p1[i]  <= '0;
            de_p1 <= 1'b0; sof_p1 <= 1'b0; eol_p1 <= 1'b0;
            x_p1  <= '0;   y_p1   <= '0;
        end else begin
            mode_p1 <= mode_p0;
            px_p1   <= px_p0;
            for (int i = 0; i < 9; i++) prod_p1[i] <= mul(coef_p0[i], in_ext(px_p0, i % 3));
            off_p1  <= off_p0;
            de_p1 <= de_p0; sof_p1 <= sof_p0; eol_p1 <= eol_p0;
            x_p1  <= x_p0;  y_p1   <= y_p0;
        end
    end

    // S2: three row sums with the rounding half added.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_p2 <= MODE_BYP;
            px_p2   <= '0;
            for (int r = 0; r < 3; r++) sum_p2[r] <= '0;
            for (int i = 0; i < 3; i++) off_p2[i] <= '0;
            de_p2 <= 1'b0; sof_p2 <= 1'b0; eol_p2 <= 1'b0;
            x_p2  <= '0;   y_p2   <= '0;
        end else begin
            mode_p2 <= mode_p1;
            px_p2   <= px_p1;
            for (int r = 0; r < 3; r++)
                sum_p2[r] <= row_sum(prod_p1[3*r], prod_p1[3*r+1], prod_p1[3*r+2]);
            off_p2  <= off_p1;
            de_p2 <= de_p1; sof_p2 <= sof_p1; eol_p2 <= eol_p1;
            x_p2  <= x_p1;  y_p2   <= y_p1;
        end
    end

    // S3: shift, offset, clamp, bypass mux and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            px_out     <= '0;
            sb_out.de  <= 1'b0;
            sb_out.sof <= 1'b0;
            sb_out.eol <= 1'b0;
            sb_out.x   <= '0;
            sb_out.y   <= '0;
        end else begin
            if (mode_p2 == MODE_BYP) begin
                px_out <= px_p2;
            end else begin
                px_out.r <= sat_pix(sum_p2[0], off_p2[0]);
                px_out.g <= sat_pix(sum_p2[1], off_p2[1]);
                px_out.b <= sat_pix(sum_p2[2], off_p2[2]);
            end
            sb_out.de  <= de_p2;
            sb_out.sof <= sof_p2;
            sb_out.eol <= eol_p2;
            sb_out.x   <= x_p2;
            sb_out.y   <= y_p2;
        end
    end

endmodule

// File: tb/tb_filt_color_matrix.sv
// Bench for filt_color_matrix: directed and random stimulus, an arithmetic
// reference model feeding a queue of expected outputs, and a monitor that
// pops and compares one entry per output cycle.

module tb_filt_color_matrix;
    import vid_pkg::*;

    localparam int XW   = 10;
    localparam int YW   = 10;
    localparam int CW   = 18;
    localparam int FRAC = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    ctrl = 2'b00;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = 4'd0;
    logic [CW-1:0] cfg_wdata = '0;
    logic          cfg_pend;
    pixel_t        px_in = '0;
    pixel_t        px_out;

    vid_sideband_if #(.XW(XW), .YW(YW)) sbi ();
    vid_sideband_if #(.XW(XW), .YW(YW)) sbo ();

    filt_color_matrix #(.XW(XW), .YW(YW), .CW(CW), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl      (ctrl),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_pend  (cfg_pend),
        .px_in     (px_in),
        .px_out    (px_out),
        .sb_in     (sbi),
        .sb_out    (sbo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        pixel_t        px;
        logic          de;
        logic          sof;
        logic          eol;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } exp_t;

    exp_t   q[$];
    exp_t   mon_e;
    longint sh[12];
    longint act[12];
    int     amode;
    bit     pend;
    bit     exp_pend;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     g601[3] = '{4899, 9617, 1868};
    int     g709[3] = '{3483, 11718, 1183};

    function automatic longint floor_div(input longint a, input longint b);
        longint d;
        d = a / b;
        if ((a % b != 0) && (a < 0)) d = d - 1;
        return d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 12; k++) sh[k] = 0;
        sh[0] = 1 << FRAC; sh[4] = 1 << FRAC; sh[8] = 1 << FRAC;
        for (int k = 0; k < 12; k++) act[k] = sh[k];
        amode = 0;
        pend  = 1'b0;
    endtask

    // One sampled clock edge of the reference: compute the response to the
    // inputs sampled now, then apply commit and shadow write.
    task automatic model_edge();
        exp_t              e;
        longint            co[12];
        longint            pin[3];
        longint            res[3];
        longint            s, v, cf;
        int                m;
        logic signed [8:0] o9;
        if (!rst_n) begin
            q.delete();
            for (int k = 0; k < 4; k++) begin
                e.due = cyc + k; e.px = '0; e.de = 1'b0; e.sof = 1'b0;
                e.eol = 1'b0; e.x = '0; e.y = '0;
                q.push_back(e);
            end
            model_reset();
        end else begin
            m = sbi.sof ? int'(ctrl) : amode;
            for (int k = 0; k < 12; k++) co[k] = sbi.sof ? sh[k] : act[k];
            pin[0] = longint'(px_in.r);
            pin[1] = longint'(px_in.g);
            pin[2] = longint'(px_in.b);
            for (int r = 0; r < 3; r++) begin
                if (m == 0) begin
                    res[r] = pin[r];
                end else begin
                    s = 0;
                    for (int c = 0; c < 3; c++) begin
                        if (m == 1)      cf = g601[c];
                        else if (m == 2) cf = g709[c];
                        else             cf = co[r*3+c];
                        s = s + cf * pin[c];
                    end
                    v = floor_div(s + (1 << (FRAC - 1)), 1 << FRAC);
                    if (m == 3) v = v + co[9+r];
                    if (v < 0) v = 0;
                    if (v > 255) v = 255;
                    res[r] = v;
                end
            end
            e.due = cyc + 3;
            e.px.r = 8'(res[0]); e.px.g = 8'(res[1]); e.px.b = 8'(res[2]);
            e.de = sbi.de; e.sof = sbi.sof; e.eol = sbi.eol; e.x = sbi.x; e.y = sbi.y;
            q.push_back(e);
            if (sbi.sof) begin
                amode = int'(ctrl);
                for (int k = 0; k < 12; k++) act[k] = sh[k];
            end
            if (cfg_we && cfg_addr <= 4'd11) begin
                if (cfg_addr < 4'd9) begin
                    sh[cfg_addr] = longint'($signed(cfg_wdata));
                end else begin
                    o9 = cfg_wdata[8:0];
                    sh[cfg_addr] = longint'(o9);
                end
                pend = 1'b1;
            end else if (sbi.sof) begin
                pend = 1'b0;
            end
        end
        exp_pend = pend;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        model_edge();
        #1;
        cfg_we  = 1'b0;
        sbi.sof = 1'b0;
        sbi.eol = 1'b0;
    endtask

    task automatic pix(input int r, input int g, input int b, input bit sof);
        px_in.r = 8'(r); px_in.g = 8'(g); px_in.b = 8'(b);
        sbi.sof = sof;
        sbi.de  = 1'b1;
        tick();
        sbi.x = XW'(int'(sbi.x) + 1);
    endtask

    task automatic wr(input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(addr);
        cfg_wdata = CW'(data);
    endtask

    // Monitor: every output cycle must match the entry due on that edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            checks = checks + 1;
            if (cfg_pend !== exp_pend) begin
                errors = errors + 1;
                $display("FAIL cfg_pend cyc=%0d got %b expected %b", cyc, cfg_pend, exp_pend);
            end
            checks = checks + 1;
            if (q.size() == 0 || q[0].due != cyc) begin
                errors = errors + 1;
                $display("FAIL scoreboard cyc=%0d no expected entry due (queue size %0d)", cyc, q.size());
            end else begin
                mon_e = q.pop_front();
                if (px_out !== mon_e.px || sbo.de !== mon_e.de || sbo.sof !== mon_e.sof ||
                    sbo.eol !== mon_e.eol || sbo.x !== mon_e.x || sbo.y !== mon_e.y) begin
                    errors = errors + 1;
                    $display("FAIL output cyc=%0d got px=%h de=%b sof=%b eol=%b x=%0d y=%0d expected px=%h de=%b sof=%b eol=%b x=%0d y=%0d",
                             cyc, px_out, sbo.de, sbo.sof, sbo.eol, sbo.x, sbo.y,
                             mon_e.px, mon_e.de, mon_e.sof, mon_e.eol, mon_e.x, mon_e.y);
                end
            end
        end
    end

    initial begin
        sbi.de = 1'b0; sbi.sof = 1'b0; sbi.eol = 1'b0; sbi.x = '0; sbi.y = '0;
        model_reset();
        exp_pend = 1'b0;

        // reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // bypass latency with sideband
        ctrl = 2'b00; sbi.x = XW'(5); sbi.y = YW'(7);
        pix(10, 20, 30, 1'b1);
        pix(1, 2, 3, 1'b0); pix(4, 5, 6, 1'b0); pix(7, 8, 9, 1'b0);

        // greyscale modes
        ctrl = 2'b01;
        pix(255, 0, 0, 1'b1); pix(255, 255, 255, 1'b0); pix(17, 99, 201, 1'b0);
        ctrl = 2'b10;
        pix(0, 255, 0, 1'b1); pix(255, 255, 255, 1'b0); pix(33, 44, 55, 1'b0);

        // custom R/B swap written mid-frame, committed on next sof
        ctrl = 2'b11;
        wr(0, 0);     pix(10, 20, 30, 1'b0);
        wr(2, 16384); pix(10, 20, 30, 1'b0);
        wr(6, 16384); pix(10, 20, 30, 1'b0);
        wr(8, 0);     pix(10, 20, 30, 1'b0);
        pix(10, 20, 30, 1'b0);
        pix(10, 20, 30, 1'b1);
        repeat (3) pix(10, 20, 30, 1'b0);

        // saturation: gain 2.0, negative gain, positive and negative offsets
        wr(0, 32768); pix(1, 1, 1, 1'b0);
        wr(2, 0);     pix(1, 1, 1, 1'b0);
        wr(6, 0);     pix(1, 1, 1, 1'b0);
        wr(8, 16384); pix(1, 1, 1, 1'b0);
        pix(200, 100, 50, 1'b1); pix(100, 0, 0, 1'b0);
        wr(0, -16384); pix(1, 1, 1, 1'b0);
        pix(50, 60, 70, 1'b1); pix(0, 0, 0, 1'b0);
        wr(0, 16384); pix(1, 1, 1, 1'b0);
        wr(9, 20);    pix(1, 1, 1, 1'b0);
        pix(250, 0, 0, 1'b1); pix(235, 0, 0, 1'b0);
        wr(9, -20);   pix(1, 1, 1, 1'b0);
        pix(10, 0, 0, 1'b1); pix(20, 0, 0, 1'b0);

        // write coincident with sof: not used this frame, applies on the next
        wr(9, 0); pix(100, 100, 100, 1'b1);
        repeat (3) pix(100, 100, 100, 1'b0);
        pix(100, 100, 100, 1'b1);
        repeat (3) pix(100, 100, 100, 1'b0);

        // reset mid-frame, then custom mode without sof stays in bypass
        ctrl = 2'b11;
        wr(2, 16384); pix(10, 20, 30, 1'b1);
        pix(11, 21, 31, 1'b0);
        rst_n = 1'b0; wr(0, 999); pix(12, 22, 32, 1'b0);
        rst_n = 1'b1;
        repeat (5) pix(10, 20, 30, 1'b0);

        // random frames: random mode, writes, pixels and sideband
        for (int f = 0; f < 40; f++) begin
            int len;
            len = int'($urandom_range(8, 24));
            ctrl  = 2'($urandom_range(0, 3));
            sbi.y = YW'(f);
            sbi.x = '0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 0)
                        wr(int'($urandom_range(0, 15)), int'($urandom_range(0, 32768)) - 16384);
                    else
                        wr(int'($urandom_range(0, 15)), int'($urandom));
                end
                if ($urandom_range(0, 250) == 0) rst_n = 1'b0;
                sbi.eol = (i == len - 1);
                sbi.de  = ($urandom_range(0, 7) != 0);
                px_in.r = 8'($urandom); px_in.g = 8'($urandom); px_in.b = 8'($urandom);
                sbi.sof = (i == 0);
                tick();
                rst_n = 1'b1;
                sbi.x = XW'(int'(sbi.x) + 1);
            end
        end

        repeat (6) pix(0, 0, 0, 1'b0);
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
